// File: rtl/bus_fifo_pkg.sv
// Shared definitions for the CPU-mapped FIFO port: register offsets,
// STATUS/CTRL bit positions and the STATUS packing helper.
package bus_fifo_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int ADDR_W        = 10;
  localparam int DATA_W        = 32;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_RXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } regOffset_e;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_TX_OVF     = 4;
  localparam int ST_RX_UNF     = 5;
  localparam int ST_TX_CNT_LSB = 8;
  localparam int ST_RX_CNT_LSB = 12;
  localparam int ST_CNT_W      = 3;

  localparam int CTRL_CLR_FLAGS = 0;
  localparam int CTRL_FLUSH     = 1;

  function automatic logic [DATA_W-1:0] packStatus(
    input logic                txFull,
    input logic                txEmpty,
    input logic                rxFull,
    input logic                rxEmpty,
    input logic                txOvf,
    input logic                rxUnf,
    input logic [ST_CNT_W-1:0] txCount,
    input logic [ST_CNT_W-1:0] rxCount
  );
    logic [DATA_W-1:0] s;
    s = '0;
    s[ST_TX_FULL]  = txFull;
    s[ST_TX_EMPTY] = txEmpty;
    s[ST_RX_FULL]  = rxFull;
    s[ST_RX_EMPTY] = rxEmpty;
    s[ST_TX_OVF]   = txOvf;
    s[ST_RX_UNF]   = rxUnf;
    s[ST_TX_CNT_LSB +: ST_CNT_W] = txCount;
    s[ST_RX_CNT_LSB +: ST_CNT_W] = rxCount;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Full/empty come from pre-edge
// state, so a push into a full FIFO is dropped even if a pop happens too.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = empty ? '0 : mem[rdPtr_q];

  // Pointers are exactly log2(DEPTH) wide, so increments wrap on their own.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (doPush && !flush) mem[wrPtr_q] <= din;
  end

endmodule

// File: rtl/bus_fifo_port.sv
// CPU-mapped TX/RX FIFO port: four-word register window on one side,
// valid/ready streams on the other.
module bus_fifo_port
  import bus_fifo_pkg::*;
#(
  parameter int                DEPTH = DEFAULT_DEPTH,
  parameter logic [ADDR_W-1:0] BASE  = 10'h3F0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] Data_BUS_WRITE,
  output logic [DATA_W-1:0] Data_BUS_READ,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] offset;
  logic              access;
  regOffset_e        regSel;
  logic              txPushReq, rxPopReq, ctrlWrite, flush, clearFlags;
  logic              txPop, rxPush;
  logic              txFull, txEmpty, rxFull, rxEmpty;
  logic [CNT_W-1:0]  txCount, rxCount;
  logic [DATA_W-1:0] txDout, rxDout;
  logic              txOvf_q, txOvf_d, rxUnf_q, rxUnf_d;
  logic [DATA_W-1:0] readData_q, readData_d;

  // Subtracting BASE keeps the window check correct even near the top of the address space.
  assign offset     = ADDR - BASE;
  assign access     = cs && (offset < 10'd4);
  assign regSel     = regOffset_e'(offset[1:0]);
  assign txPushReq  = access && we  && (regSel == REG_TXDATA);
  assign rxPopReq   = access && !we && (regSel == REG_RXDATA);
  assign ctrlWrite  = access && we  && (regSel == REG_CTRL);
  assign flush      = ctrlWrite && Data_BUS_WRITE[CTRL_FLUSH];
  assign clearFlags = ctrlWrite && Data_BUS_WRITE[CTRL_CLR_FLAGS];

  assign tx_valid = !txEmpty;
  assign tx_data  = txDout;
  assign rx_ready = !rxFull;
  assign txPop    = tx_valid && tx_ready;
  assign rxPush   = rx_valid && rx_ready;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) txFifo (
    .clock (clock),
    .reset (reset),
    .push  (txPushReq),
    .pop   (txPop),
    .flush (flush),
    .din   (Data_BUS_WRITE),
    .dout  (txDout),
    .full  (txFull),
    .empty (txEmpty),
    .count (txCount)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) rxFifo (
    .clock (clock),
    .reset (reset),
    .push  (rxPush),
    .pop   (rxPopReq),
    .flush (flush),
    .din   (rx_data),
    .dout  (rxDout),
    .full  (rxFull),
    .empty (rxEmpty),
    .count (rxCount)
  );

  always_comb begin
    txOvf_d = txOvf_q;
    rxUnf_d = rxUnf_q;
    if (clearFlags) begin
      txOvf_d = 1'b0;
      rxUnf_d = 1'b0;
    end else begin
      if (txPushReq && txFull) txOvf_d = 1'b1;
      if (rxPopReq && rxEmpty) rxUnf_d = 1'b1;
    end
  end

  // Read data only moves on a read access; the FIFO output is already zero when empty.
  always_comb begin
    readData_d = readData_q;
    if (access && !we) begin
      case (regSel)
        REG_RXDATA: readData_d = rxDout;
        REG_STATUS: readData_d = packStatus(txFull, txEmpty, rxFull, rxEmpty,
                                            txOvf_q, rxUnf_q,
                                            ST_CNT_W'(txCount), ST_CNT_W'(rxCount));
        default:    readData_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      txOvf_q    <= 1'b0;
      rxUnf_q    <= 1'b0;
      readData_q <= '0;
    end else begin
      txOvf_q    <= txOvf_d;
      rxUnf_q    <= rxUnf_d;
      readData_q <= readData_d;
    end
  end

  assign Data_BUS_READ = readData_q;

endmodule

// File: tb/tb_bus_fifo_port.sv
// Directed and randomized checks of bus_fifo_port against a queue-based
// reference model of the register window and both streams.
module tb_bus_fifo_port;

  localparam int          DEPTH = 4;
  localparam logic [9:0]  BASE  = 10'h3F0;

  logic        clock = 1'b0;
  logic        reset;
  logic        cs, we;
  logic [9:0]  ADDR;
  logic [31:0] Data_BUS_WRITE, Data_BUS_READ;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [31:0] tx_data, rx_data;

  int testsRun  = 0;
  int failCount = 0;

  logic [31:0] txQ[$];
  logic [31:0] rxQ[$];
  bit          mOvf, mUnf;
  logic [31:0] expRead;

  bus_fifo_port #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clock          (clock),
    .reset          (reset),
    .cs             (cs),
    .we             (we),
    .ADDR           (ADDR),
    .Data_BUS_WRITE (Data_BUS_WRITE),
    .Data_BUS_READ  (Data_BUS_READ),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    int unsigned tc = txQ.size();
    int unsigned rc = rxQ.size();
    logic [31:0] s;
    s = 32'(tc == DEPTH) + 32'(tc == 0) * 2 + 32'(rc == DEPTH) * 4 + 32'(rc == 0) * 8
      + 32'(mOvf) * 16 + 32'(mUnf) * 32 + 32'(tc) * 256 + 32'(rc) * 4096;
    return s;
  endfunction

  task automatic resetModel();
    txQ.delete();
    rxQ.delete();
    mOvf    = 1'b0;
    mUnf    = 1'b0;
    expRead = 32'h0;
  endtask

  // Drive one cycle, advance the model with the pre-edge rules, then compare after the edge.
  task automatic applyStimulus(input string tag, input bit c, input bit w, input logic [9:0] a,
                               input logic [31:0] wd, input bit tr, input bit rv, input logic [31:0] rd);
    logic [9:0] offs;
    bit acc, preTxFull, preTxEmpty, preRxFull, preRxEmpty;
    bit txPop, rxPush, cpuPush, cpuPop, doFlush, doClear;
    cs = c; we = w; ADDR = a; Data_BUS_WRITE = wd;
    tx_ready = tr; rx_valid = rv; rx_data = rd;

    offs       = a - BASE;
    acc        = c && (offs < 10'd4);
    preTxFull  = txQ.size() == DEPTH;
    preTxEmpty = txQ.size() == 0;
    preRxFull  = rxQ.size() == DEPTH;
    preRxEmpty = rxQ.size() == 0;
    txPop      = tr && !preTxEmpty;
    rxPush     = rv && !preRxFull;
    cpuPush    = acc && w && offs == 10'd0;
    cpuPop     = acc && !w && offs == 10'd1;
    doFlush    = acc && w && offs == 10'd3 && wd[1];
    doClear    = acc && w && offs == 10'd3 && wd[0];

    if (acc && !w) begin
      if (offs == 10'd1)      expRead = preRxEmpty ? 32'h0 : rxQ[0];
      else if (offs == 10'd2) expRead = modelStatus();
      else                    expRead = 32'h0;
    end
    if (cpuPush && preTxFull) mOvf = 1'b1;
    if (cpuPop && preRxEmpty) mUnf = 1'b1;
    if (doClear) begin mOvf = 1'b0; mUnf = 1'b0; end
    if (doFlush) begin
      txQ.delete();
      rxQ.delete();
    end else begin
      if (txPop) void'(txQ.pop_front());
      if (cpuPush && !preTxFull) txQ.push_back(wd);
      if (cpuPop && !preRxEmpty) void'(rxQ.pop_front());
      if (rxPush) rxQ.push_back(rd);
    end

    @(posedge clock);
    #1;
    checkOutput({tag, ".rdata"},    Data_BUS_READ, expRead);
    checkOutput({tag, ".tx_valid"}, 32'(tx_valid), 32'(txQ.size() != 0));
    checkOutput({tag, ".tx_data"},  tx_data, (txQ.size() != 0) ? txQ[0] : 32'h0);
    checkOutput({tag, ".rx_ready"}, 32'(rx_ready), 32'(rxQ.size() < DEPTH));
  endtask

  task automatic busWrite(input string tag, input logic [9:0] a, input logic [31:0] d);
    applyStimulus(tag, 1'b1, 1'b1, a, d, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic busRead(input string tag, input logic [9:0] a);
    applyStimulus(tag, 1'b1, 1'b0, a, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic idle(input string tag, input bit tr);
    applyStimulus(tag, 1'b0, 1'b0, 10'h0, 32'h0, tr, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] seq[4];
    bit          rc, rw, rtr, rrv;
    logic [9:0]  ra;
    logic [31:0] rwd;

    reset = 1'b1; cs = 1'b0; we = 1'b0; ADDR = '0; Data_BUS_WRITE = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    resetModel();
    #1;
    checkOutput("reset.rdata",    Data_BUS_READ, 32'h0);
    checkOutput("reset.tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("reset.tx_data",  tx_data, 32'h0);
    checkOutput("reset.rx_ready", 32'(rx_ready), 32'h1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Post-reset STATUS
    busRead("st0", 10'h3F2);
    checkOutput("st0.const", Data_BUS_READ, 32'h0000_000A);

    // TX fill past full, then drain in order
    busWrite("tx0", 10'h3F0, 32'h11);
    busWrite("tx1", 10'h3F0, 32'h22);
    busWrite("tx2", 10'h3F0, 32'h33);
    busWrite("tx3", 10'h3F0, 32'h44);
    busWrite("tx4", 10'h3F0, 32'h55);
    busRead("st1", 10'h3F2);
    checkOutput("st1.const", Data_BUS_READ, 32'h0000_0419);
    checkOutput("drain.head", tx_data, 32'h11);
    seq = '{32'h22, 32'h33, 32'h44, 32'h0};
    for (int k = 0; k < 4; k++) begin
      idle("drain", 1'b1);
      checkOutput("drain.seq", tx_data, seq[k]);
    end
    checkOutput("drain.valid", 32'(tx_valid), 32'h0);

    // RX receive, pop twice, underflow on third
    applyStimulus("rx0", 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b1, 32'hA5A5_0001);
    applyStimulus("rx1", 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b1, 32'hA5A5_0002);
    busRead("rxr0", 10'h3F1);
    checkOutput("rxr0.const", Data_BUS_READ, 32'hA5A5_0001);
    busRead("rxr1", 10'h3F1);
    checkOutput("rxr1.const", Data_BUS_READ, 32'hA5A5_0002);
    busRead("rxr2", 10'h3F1);
    checkOutput("rxr2.const", Data_BUS_READ, 32'h0);
    busRead("st2", 10'h3F2);
    checkOutput("st2.unf", 32'(Data_BUS_READ[5]), 32'h1);

    // Push to full TX while a pop happens: push dropped
    busWrite("clr", 10'h3F3, 32'h1);
    busWrite("f0", 10'h3F0, 32'h61);
    busWrite("f1", 10'h3F0, 32'h62);
    busWrite("f2", 10'h3F0, 32'h63);
    busWrite("f3", 10'h3F0, 32'h64);
    applyStimulus("fpush", 1'b1, 1'b1, 10'h3F0, 32'h99, 1'b1, 1'b0, 32'h0);
    busRead("st3", 10'h3F2);
    checkOutput("st3.const", Data_BUS_READ, 32'h0000_0318);
    checkOutput("fdrain.head", tx_data, 32'h62);
    seq = '{32'h63, 32'h64, 32'h0, 32'h0};
    for (int k = 0; k < 4; k++) begin
      idle("fdrain", 1'b1);
      checkOutput("fdrain.seq", tx_data, seq[k]);
    end

    // Flush + clear with data and flags present, RX word offered during flush
    busRead("unf", 10'h3F1);
    for (int k = 0; k < 5; k++) busWrite("ffill", 10'h3F0, 32'h100 + 32'(k));
    applyStimulus("rxa", 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b1, 32'hBEEF_0001);
    applyStimulus("rxb", 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b1, 32'hBEEF_0002);
    applyStimulus("flush", 1'b1, 1'b1, 10'h3F3, 32'h3, 1'b0, 1'b1, 32'hBEEF_0003);
    busRead("st4", 10'h3F2);
    checkOutput("st4.const", Data_BUS_READ, 32'h0000_000A);

    // Out-of-window accesses must do nothing
    busWrite("oow0", 10'h3EF, 32'h77);
    busWrite("oow1", 10'h3F4, 32'h3);
    busRead("oow2", 10'h3F4);
    checkOutput("oow.tx_valid", 32'(tx_valid), 32'h0);

    // Async reset mid-stream
    busWrite("ar0", 10'h3F0, 32'hC1);
    busWrite("ar1", 10'h3F0, 32'hC2);
    busRead("ar.st", 10'h3F2);
    checkOutput("ar.st.const", Data_BUS_READ, 32'h0000_0208);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("ar.tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("ar.tx_data",  tx_data, 32'h0);
    checkOutput("ar.rdata",    Data_BUS_READ, 32'h0);
    checkOutput("ar.rx_ready", 32'(rx_ready), 32'h1);
    resetModel();
    @(posedge clock);
    #1;
    reset = 1'b0;
    busRead("ar.st2", 10'h3F2);
    checkOutput("ar.st2.const", Data_BUS_READ, 32'h0000_000A);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rc  = $urandom_range(0, 3) != 0;
      rw  = $urandom_range(0, 1) == 1;
      rtr = $urandom_range(0, 2) == 0;
      rrv = $urandom_range(0, 1) == 1;
      rwd = $urandom;
      case ($urandom_range(0, 9))
        0:       ra = 10'(BASE - 10'd1);
        1:       ra = 10'(BASE + 10'd4);
        2:       ra = 10'($urandom);
        default: ra = 10'(BASE + 10'($urandom_range(0, 3)));
      endcase
      if (ra == 10'(BASE + 10'd3) && $urandom_range(0, 3) != 0) rwd[1] = 1'b0;
      applyStimulus("rand", rc, rw, ra, rwd, rtr, rrv, $urandom);
    end
    busRead("final.st", 10'h3F2);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
